mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access stage directly downstream of the cushion merge stage. Takes the merged
//  per-instruction bundle, performs loads/stores on the data bus with a req/ack handshake,
//  aligns and sign-extends load data, and presents a registered writeback bundle.
//  Stalls upstream via MEM_WAIT (drives cushion MMU_WAIT) while a bus access is outstanding.
// PARAMETERS
//  TIMEOUT  32'd256  cycles in BUS without DBUS_ACK before access-fault abort (0 = no timeout)
// PORTS
//  CLK              in   1   clock
//  RST              in   1   synchronous, active-high reset
//  FLUSH            in   1   discard accepted/in-flight instruction
//  MEM_WAIT         out  1   stall upstream; high whenever state != IDLE
//  IN_VALID, IN_PC  in   1/32  instruction valid, PC
//  IN_REG_W_{EN,RD,DATA}               in  1/5/32    ALU register write
//  IN_CSR_W_{EN,ADDR,DATA}             in  1/12/32   CSR write (passthrough)
//  IN_MEM_R_{EN,RD,ADDR,STRB,SIGNED}   in  1/5/32/4/1 load request
//  IN_MEM_W_{EN,ADDR,STRB,DATA}        in  1/32/4/32 store request
//  IN_JMP_{DO,PC}, IN_EXC_{EN,CODE}    in  1/32, 1/4  jump, upstream exception
//  DBUS_REQ, DBUS_WE out 1/1   bus request (held until ack), write enable
//  DBUS_ADDR, DBUS_STRB, DBUS_WDATA out 32/4/32  word address, lane strobe, lane-shifted data
//  DBUS_ACK, DBUS_ERR in 1/1   completion (1-cycle pulse), error qualifier valid with ACK
//  DBUS_RDATA       in   32  read word, valid with ACK
//  WB_VALID, WB_PC  out  1/32  writeback valid (1-cycle per instr), PC
//  WB_REG_W_{EN,RD,DATA}, WB_CSR_W_{EN,ADDR,DATA}, WB_JMP_{DO,PC}, WB_EXC_{EN,CODE}  out
// BEHAVIOUR
//  Reset: state IDLE; MEM_WAIT, DBUS_*, all WB_* outputs 0; timeout counter 0.
//  States: IDLE, BUS, DRAIN. Input sampled only in IDLE with FLUSH=0.
//  IDLE, IN_VALID=0 -> next cycle WB_VALID=0, all WB fields 0.
//  IDLE, IN_VALID=1, no bus op needed -> WB_* = IN_* registered, latency 1, stay IDLE.
//  Bus op needed iff (MEM_R_EN|MEM_W_EN) & !EXC_EN & aligned. Both EN set: load wins.
//  STRB is unshifted (0001 byte, 0011 half, 1111 word). Misaligned: half with addr[0]=1,
//   word with addr[1:0]!=0 -> no bus, WB_EXC_EN=1, code 4 (load) / 6 (store), latency 1.
//  Priority: IN_EXC_EN (passed through, no bus) > misaligned > bus access.
//  Accept bus op -> BUS next cycle: DBUS_REQ=1, DBUS_ADDR={addr[31:2],2'b00},
//   DBUS_STRB=STRB<<addr[1:0], DBUS_WDATA=DATA<<(8*addr[1:0]); fields stable until ACK.
//  BUS, DBUS_ACK=1 -> IDLE; next cycle DBUS_REQ=0 and WB_VALID=1 with result.
//   Load: d=RDATA>>(8*addr[1:0]), masked to strb width, sign-ext if SIGNED else zero-ext;
//    WB_REG_W_EN=(MEM_R_RD!=0), WB_REG_W_RD=MEM_R_RD, WB_REG_W_DATA=d.
//   Store: WB_REG_W_* = latched IN_REG_W_*.
//   DBUS_ERR=1 with ACK -> WB_EXC_EN=1, code 5 (load) / 7 (store), WB_REG_W_EN=0.
//  Timeout: counter counts in BUS; reaching TIMEOUT-1 w/o ACK -> DRAIN, result = access fault.
//  FLUSH in IDLE: no capture, next WB_VALID=0. FLUSH in BUS: request kept (no bus abort),
//   go DRAIN, result discarded. DRAIN: DBUS_REQ held until ACK, then IDLE, WB_VALID=0.
//  Timeout-DRAIN: DBUS_REQ dropped immediately, exits IDLE the next cycle with the fault WB.
//  MEM_WAIT combinational = (state!=IDLE); one bubble cycle after each bus op.
//  RST mid-operation: immediate return to reset values; bus slave must tolerate dropped REQ.
// TESTING
//  ALU op PC=0x100, rd=5, data=0xDEAD -> next cycle WB_VALID=1, RD=5, DATA=0xDEAD, MEM_WAIT=0.
//  LB signed addr=0x2003, RDATA=0x80xxxxxx, ACK after 3 cycles -> DBUS_STRB=1000, MEM_WAIT 4 cyc,
//   WB_REG_W_DATA=0xFFFFFF80.
//  SH addr=0x1002 data=0x1234 -> DBUS_ADDR=0x1000, STRB=1100, WDATA=0x12340000, WE=1.
//  LW addr=0x1001 -> no DBUS_REQ, WB_EXC_EN=1, code 4 next cycle.
//  LW with ACK+ERR -> WB_EXC code 5, REG_W_EN=0; no ACK for 256 cycles -> code 5, REQ dropped.
//  FLUSH during BUS then ACK 2 cycles later -> REQ held to ACK, WB_VALID stays 0, then IDLE.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on a req/ack data bus, aligns and extends load
// data, and presents a registered writeback bundle; stalls upstream while a bus op is open.
module mem_access #(
    parameter logic [31:0] TIMEOUT = 32'd256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    output logic        MEM_WAIT,
    input  logic        IN_VALID,
    input  logic [31:0] IN_PC,
    input  logic        IN_REG_W_EN,
    input  logic [4:0]  IN_REG_W_RD,
    input  logic [31:0] IN_REG_W_DATA,
    input  logic        IN_CSR_W_EN,
    input  logic [11:0] IN_CSR_W_ADDR,
    input  logic [31:0] IN_CSR_W_DATA,
    input  logic        IN_MEM_R_EN,
    input  logic [4:0]  IN_MEM_R_RD,
    input  logic [31:0] IN_MEM_R_ADDR,
    input  logic [3:0]  IN_MEM_R_STRB,
    input  logic        IN_MEM_R_SIGNED,
    input  logic        IN_MEM_W_EN,
    input  logic [31:0] IN_MEM_W_ADDR,
    input  logic [3:0]  IN_MEM_W_STRB,
    input  logic [31:0] IN_MEM_W_DATA,
    input  logic        IN_JMP_DO,
    input  logic [31:0] IN_JMP_PC,
    input  logic        IN_EXC_EN,
    input  logic [3:0]  IN_EXC_CODE,
    output logic        DBUS_REQ,
    output logic        DBUS_WE,
    output logic [31:0] DBUS_ADDR,
    output logic [3:0]  DBUS_STRB,
    output logic [31:0] DBUS_WDATA,
    input  logic        DBUS_ACK,
    input  logic        DBUS_ERR,
    input  logic [31:0] DBUS_RDATA,
    output logic        WB_VALID,
    output logic [31:0] WB_PC,
    output logic        WB_REG_W_EN,
    output logic [4:0]  WB_REG_W_RD,
    output logic [31:0] WB_REG_W_DATA,
    output logic        WB_CSR_W_EN,
    output logic [11:0] WB_CSR_W_ADDR,
    output logic [31:0] WB_CSR_W_DATA,
    output logic        WB_JMP_DO,
    output logic [31:0] WB_JMP_PC,
    output logic        WB_EXC_EN,
    output logic [3:0]  WB_EXC_CODE
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DRAIN} state_t;

    state_t      state_reg;
    logic [31:0] count_reg;
    logic        fault_reg;
    logic        load_reg;
    logic        signed_reg;
    logic [1:0]  lane_reg;
    logic [3:0]  strb_reg;
    logic [4:0]  load_rd_reg;
    logic [31:0] pc_reg;
    logic        reg_w_en_reg;
    logic [4:0]  reg_w_rd_reg;
    logic [31:0] reg_w_data_reg;
    logic        csr_w_en_reg;
    logic [11:0] csr_w_addr_reg;
    logic [31:0] csr_w_data_reg;
    logic        jmp_do_reg;
    logic [31:0] jmp_pc_reg;

    // Request decode: a load takes precedence when both enables are set.
    logic        is_load;
    logic        mem_op;
    logic [31:0] op_addr;
    logic [3:0]  op_strb;
    logic        misaligned;
    logic        timeout_hit;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign is_load    = IN_MEM_R_EN;
    assign mem_op     = IN_MEM_R_EN | IN_MEM_W_EN;
    assign op_addr    = IN_MEM_R_EN ? IN_MEM_R_ADDR : IN_MEM_W_ADDR;
    assign op_strb    = IN_MEM_R_EN ? IN_MEM_R_STRB : IN_MEM_W_STRB;
    assign misaligned = ((op_strb == 4'b0011) && op_addr[0]) ||
                        ((op_strb == 4'b1111) && (op_addr[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT != 32'd0) && (count_reg == TIMEOUT - 32'd1);
    assign MEM_WAIT   = (state_reg != ST_IDLE);

    assign rdata_shifted = DBUS_RDATA >> {lane_reg, 3'b000};

    always_comb begin
        load_data = rdata_shifted;
        case (strb_reg)
            4'b0001: load_data = {{24{signed_reg & rdata_shifted[7]}},  rdata_shifted[7:0]};
            4'b0011: load_data = {{16{signed_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            fault_reg      <= 1'b0;
            load_reg       <= 1'b0;
            signed_reg     <= 1'b0;
            lane_reg       <= '0;
            strb_reg       <= '0;
            load_rd_reg    <= '0;
            pc_reg         <= '0;
            reg_w_en_reg   <= 1'b0;
            reg_w_rd_reg   <= '0;
            reg_w_data_reg <= '0;
            csr_w_en_reg   <= 1'b0;
            csr_w_addr_reg <= '0;
            csr_w_data_reg <= '0;
            jmp_do_reg     <= 1'b0;
            jmp_pc_reg     <= '0;
            DBUS_REQ       <= 1'b0;
            DBUS_WE        <= 1'b0;
            DBUS_ADDR      <= '0;
            DBUS_STRB      <= '0;
            DBUS_WDATA     <= '0;
            WB_VALID       <= 1'b0;
            WB_PC          <= '0;
            WB_REG_W_EN    <= 1'b0;
            WB_REG_W_RD    <= '0;
            WB_REG_W_DATA  <= '0;
            WB_CSR_W_EN    <= 1'b0;
            WB_CSR_W_ADDR  <= '0;
            WB_CSR_W_DATA  <= '0;
            WB_JMP_DO      <= 1'b0;
            WB_JMP_PC      <= '0;
            WB_EXC_EN      <= 1'b0;
            WB_EXC_CODE    <= '0;
        end else begin
            // Writeback is a one-cycle pulse; every field is zero when not valid.
            WB_VALID      <= 1'b0;
            WB_PC         <= '0;
            WB_REG_W_EN   <= 1'b0;
            WB_REG_W_RD   <= '0;
            WB_REG_W_DATA <= '0;
            WB_CSR_W_EN   <= 1'b0;
            WB_CSR_W_ADDR <= '0;
            WB_CSR_W_DATA <= '0;
            WB_JMP_DO     <= 1'b0;
            WB_JMP_PC     <= '0;
            WB_EXC_EN     <= 1'b0;
            WB_EXC_CODE   <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (IN_VALID && !FLUSH) begin
                        if (mem_op && !IN_EXC_EN && !misaligned) begin
                            state_reg      <= ST_BUS;
                            count_reg      <= '0;
                            fault_reg      <= 1'b0;
                            load_reg       <= is_load;
                            signed_reg     <= IN_MEM_R_SIGNED;
                            lane_reg       <= op_addr[1:0];
                            strb_reg       <= op_strb;
                            load_rd_reg    <= IN_MEM_R_RD;
                            pc_reg         <= IN_PC;
                            reg_w_en_reg   <= IN_REG_W_EN;
                            reg_w_rd_reg   <= IN_REG_W_RD;
                            reg_w_data_reg <= IN_REG_W_DATA;
                            csr_w_en_reg   <= IN_CSR_W_EN;
                            csr_w_addr_reg <= IN_CSR_W_ADDR;
                            csr_w_data_reg <= IN_CSR_W_DATA;
                            jmp_do_reg     <= IN_JMP_DO;
                            jmp_pc_reg     <= IN_JMP_PC;
                            DBUS_REQ       <= 1'b1;
                            DBUS_WE        <= !is_load;
                            DBUS_ADDR      <= {op_addr[31:2], 2'b00};
                            DBUS_STRB      <= op_strb << op_addr[1:0];
                            DBUS_WDATA     <= is_load ? 32'd0 : (IN_MEM_W_DATA << {op_addr[1:0], 3'b000});
                        end else begin
                            WB_VALID      <= 1'b1;
                            WB_PC         <= IN_PC;
                            WB_REG_W_EN   <= IN_REG_W_EN;
                            WB_REG_W_RD   <= IN_REG_W_RD;
                            WB_REG_W_DATA <= IN_REG_W_DATA;
                            WB_CSR_W_EN   <= IN_CSR_W_EN;
                            WB_CSR_W_ADDR <= IN_CSR_W_ADDR;
                            WB_CSR_W_DATA <= IN_CSR_W_DATA;
                            WB_JMP_DO     <= IN_JMP_DO;
                            WB_JMP_PC     <= IN_JMP_PC;
                            WB_EXC_EN     <= IN_EXC_EN;
                            WB_EXC_CODE   <= IN_EXC_CODE;
                            if (!IN_EXC_EN && mem_op && misaligned) begin
                                WB_REG_W_EN <= 1'b0;
                                WB_EXC_EN   <= 1'b1;
                                WB_EXC_CODE <= is_load ? 4'd4 : 4'd6;
                            end
                        end
                    end
                end

                ST_BUS: begin
                    if (DBUS_ACK) begin
                        state_reg  <= ST_IDLE;
                        DBUS_REQ   <= 1'b0;
                        DBUS_WE    <= 1'b0;
                        DBUS_ADDR  <= '0;
                        DBUS_STRB  <= '0;
                        DBUS_WDATA <= '0;
                        if (!FLUSH) begin
                            WB_VALID      <= 1'b1;
                            WB_PC         <= pc_reg;
                            WB_CSR_W_EN   <= csr_w_en_reg;
                            WB_CSR_W_ADDR <= csr_w_addr_reg;
                            WB_CSR_W_DATA <= csr_w_data_reg;
                            WB_JMP_DO     <= jmp_do_reg;
                            WB_JMP_PC     <= jmp_pc_reg;
                            if (DBUS_ERR) begin
                                WB_EXC_EN   <= 1'b1;
                                WB_EXC_CODE <= load_reg ? 4'd5 : 4'd7;
                            end else if (load_reg) begin
                                WB_REG_W_EN   <= (load_rd_reg != 5'd0);
                                WB_REG_W_RD   <= load_rd_reg;
                                WB_REG_W_DATA <= load_data;
                            end else begin
                                WB_REG_W_EN   <= reg_w_en_reg;
                                WB_REG_W_RD   <= reg_w_rd_reg;
                                WB_REG_W_DATA <= reg_w_data_reg;
                            end
                        end
                    end else if (FLUSH) begin
                        // The bus cannot be aborted: keep requesting and throw the result away.
                        state_reg <= ST_DRAIN;
                        fault_reg <= 1'b0;
                        count_reg <= count_reg + 32'd1;
                    end else if (timeout_hit) begin
                        state_reg  <= ST_DRAIN;
                        fault_reg  <= 1'b1;
                        DBUS_REQ   <= 1'b0;
                        DBUS_WE    <= 1'b0;
                        DBUS_ADDR  <= '0;
                        DBUS_STRB  <= '0;
                        DBUS_WDATA <= '0;
                    end else begin
                        count_reg <= count_reg + 32'd1;
                    end
                end

                ST_DRAIN: begin
                    if (fault_reg) begin
                        state_reg <= ST_IDLE;
                        fault_reg <= 1'b0;
                        if (!FLUSH) begin
                            WB_VALID      <= 1'b1;
                            WB_PC         <= pc_reg;
                            WB_CSR_W_EN   <= csr_w_en_reg;
                            WB_CSR_W_ADDR <= csr_w_addr_reg;
                            WB_CSR_W_DATA <= csr_w_data_reg;
                            WB_JMP_DO     <= jmp_do_reg;
                            WB_JMP_PC     <= jmp_pc_reg;
                            WB_EXC_EN     <= 1'b1;
                            WB_EXC_CODE   <= load_reg ? 4'd5 : 4'd7;
                        end
                    end else if (DBUS_ACK || timeout_hit) begin
                        state_reg  <= ST_IDLE;
                        DBUS_REQ   <= 1'b0;
                        DBUS_WE    <= 1'b0;
                        DBUS_ADDR  <= '0;
                        DBUS_STRB  <= '0;
                        DBUS_WDATA <= '0;
                    end else begin
                        count_reg <= count_reg + 32'd1;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU passthrough, loads/stores, misalignment,
// bus error, timeout, flush handling and reset mid-operation.
module tb_mem_access;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        MEM_WAIT;
    logic        IN_VALID;
    logic [31:0] IN_PC;
    logic        IN_REG_W_EN;
    logic [4:0]  IN_REG_W_RD;
    logic [31:0] IN_REG_W_DATA;
    logic        IN_CSR_W_EN;
    logic [11:0] IN_CSR_W_ADDR;
    logic [31:0] IN_CSR_W_DATA;
    logic        IN_MEM_R_EN;
    logic [4:0]  IN_MEM_R_RD;
    logic [31:0] IN_MEM_R_ADDR;
    logic [3:0]  IN_MEM_R_STRB;
    logic        IN_MEM_R_SIGNED;
    logic        IN_MEM_W_EN;
    logic [31:0] IN_MEM_W_ADDR;
    logic [3:0]  IN_MEM_W_STRB;
    logic [31:0] IN_MEM_W_DATA;
    logic        IN_JMP_DO;
    logic [31:0] IN_JMP_PC;
    logic        IN_EXC_EN;
    logic [3:0]  IN_EXC_CODE;
    logic        DBUS_REQ;
    logic        DBUS_WE;
    logic [31:0] DBUS_ADDR;
    logic [3:0]  DBUS_STRB;
    logic [31:0] DBUS_WDATA;
    logic        DBUS_ACK;
    logic        DBUS_ERR;
    logic [31:0] DBUS_RDATA;
    logic        WB_VALID;
    logic [31:0] WB_PC;
    logic        WB_REG_W_EN;
    logic [4:0]  WB_REG_W_RD;
    logic [31:0] WB_REG_W_DATA;
    logic        WB_CSR_W_EN;
    logic [11:0] WB_CSR_W_ADDR;
    logic [31:0] WB_CSR_W_DATA;
    logic        WB_JMP_DO;
    logic [31:0] WB_JMP_PC;
    logic        WB_EXC_EN;
    logic [3:0]  WB_EXC_CODE;

    int vec_count   = 0;
    int miscompares = 0;

    mem_access #(.TIMEOUT(32'd256)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .IN_VALID(IN_VALID), .IN_PC(IN_PC),
        .IN_REG_W_EN(IN_REG_W_EN), .IN_REG_W_RD(IN_REG_W_RD), .IN_REG_W_DATA(IN_REG_W_DATA),
        .IN_CSR_W_EN(IN_CSR_W_EN), .IN_CSR_W_ADDR(IN_CSR_W_ADDR), .IN_CSR_W_DATA(IN_CSR_W_DATA),
        .IN_MEM_R_EN(IN_MEM_R_EN), .IN_MEM_R_RD(IN_MEM_R_RD), .IN_MEM_R_ADDR(IN_MEM_R_ADDR),
        .IN_MEM_R_STRB(IN_MEM_R_STRB), .IN_MEM_R_SIGNED(IN_MEM_R_SIGNED),
        .IN_MEM_W_EN(IN_MEM_W_EN), .IN_MEM_W_ADDR(IN_MEM_W_ADDR),
        .IN_MEM_W_STRB(IN_MEM_W_STRB), .IN_MEM_W_DATA(IN_MEM_W_DATA),
        .IN_JMP_DO(IN_JMP_DO), .IN_JMP_PC(IN_JMP_PC),
        .IN_EXC_EN(IN_EXC_EN), .IN_EXC_CODE(IN_EXC_CODE),
        .DBUS_REQ(DBUS_REQ), .DBUS_WE(DBUS_WE), .DBUS_ADDR(DBUS_ADDR),
        .DBUS_STRB(DBUS_STRB), .DBUS_WDATA(DBUS_WDATA),
        .DBUS_ACK(DBUS_ACK), .DBUS_ERR(DBUS_ERR), .DBUS_RDATA(DBUS_RDATA),
        .WB_VALID(WB_VALID), .WB_PC(WB_PC),
        .WB_REG_W_EN(WB_REG_W_EN), .WB_REG_W_RD(WB_REG_W_RD), .WB_REG_W_DATA(WB_REG_W_DATA),
        .WB_CSR_W_EN(WB_CSR_W_EN), .WB_CSR_W_ADDR(WB_CSR_W_ADDR), .WB_CSR_W_DATA(WB_CSR_W_DATA),
        .WB_JMP_DO(WB_JMP_DO), .WB_JMP_PC(WB_JMP_PC),
        .WB_EXC_EN(WB_EXC_EN), .WB_EXC_CODE(WB_EXC_CODE)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        FLUSH = 0; IN_VALID = 0; IN_PC = 0;
        IN_REG_W_EN = 0; IN_REG_W_RD = 0; IN_REG_W_DATA = 0;
        IN_CSR_W_EN = 0; IN_CSR_W_ADDR = 0; IN_CSR_W_DATA = 0;
        IN_MEM_R_EN = 0; IN_MEM_R_RD = 0; IN_MEM_R_ADDR = 0; IN_MEM_R_STRB = 0; IN_MEM_R_SIGNED = 0;
        IN_MEM_W_EN = 0; IN_MEM_W_ADDR = 0; IN_MEM_W_STRB = 0; IN_MEM_W_DATA = 0;
        IN_JMP_DO = 0; IN_JMP_PC = 0; IN_EXC_EN = 0; IN_EXC_CODE = 0;
        DBUS_ACK = 0; DBUS_ERR = 0; DBUS_RDATA = 0;
    endtask

    task automatic drive_load(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] addr,
                              input logic [3:0] strb, input logic sgn);
        IN_VALID = 1; IN_PC = pc; IN_MEM_R_EN = 1; IN_MEM_R_RD = rd;
        IN_MEM_R_ADDR = addr; IN_MEM_R_STRB = strb; IN_MEM_R_SIGNED = sgn;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        tick(); tick();
        vec_count++; if (MEM_WAIT !== 1'b0) begin $display("FAIL reset_mem_wait got=%b exp=0", MEM_WAIT); miscompares++; end
        vec_count++; if (DBUS_REQ !== 1'b0) begin $display("FAIL reset_dbus_req got=%b exp=0", DBUS_REQ); miscompares++; end
        vec_count++; if ({WB_VALID, WB_REG_W_DATA, WB_EXC_EN} !== 34'd0) begin $display("FAIL reset_wb got=%b/%h/%b exp=0", WB_VALID, WB_REG_W_DATA, WB_EXC_EN); miscompares++; end
        RST = 0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_alu();
        IN_VALID = 1; IN_PC = 32'h100; IN_REG_W_EN = 1; IN_REG_W_RD = 5; IN_REG_W_DATA = 32'hDEAD;
        tick();
        vec_count++; if (WB_VALID !== 1'b1) begin $display("FAIL alu_valid got=%b exp=1", WB_VALID); miscompares++; end
        vec_count++; if (WB_REG_W_RD !== 5'd5 || WB_REG_W_DATA !== 32'hDEAD) begin $display("FAIL alu_rd_data got=%0d/%h exp=5/0000dead", WB_REG_W_RD, WB_REG_W_DATA); miscompares++; end
        vec_count++; if (WB_PC !== 32'h100 || MEM_WAIT !== 1'b0) begin $display("FAIL alu_pc_wait got=%h/%b exp=00000100/0", WB_PC, MEM_WAIT); miscompares++; end
        clear_inputs();
        tick();
        vec_count++; if (WB_VALID !== 1'b0 || WB_REG_W_DATA !== 32'd0) begin $display("FAIL alu_idle got=%b/%h exp=0/0", WB_VALID, WB_REG_W_DATA); miscompares++; end
        $display("alu: pc=100 rd=5 data=dead");
    endtask

    task automatic test_load_byte_signed();
        int waits = 0;
        drive_load(32'h200, 5'd7, 32'h2003, 4'b0001, 1'b1);
        tick();
        clear_inputs();
        vec_count++; if (DBUS_REQ !== 1'b1 || DBUS_WE !== 1'b0) begin $display("FAIL lb_req got=%b/%b exp=1/0", DBUS_REQ, DBUS_WE); miscompares++; end
        vec_count++; if (DBUS_ADDR !== 32'h2000 || DBUS_STRB !== 4'b1000) begin $display("FAIL lb_addr_strb got=%h/%b exp=00002000/1000", DBUS_ADDR, DBUS_STRB); miscompares++; end
        if (MEM_WAIT) waits++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (MEM_WAIT) waits++;
        end
        DBUS_ACK = 1; DBUS_RDATA = 32'h80123456;
        tick();
        DBUS_ACK = 0;
        vec_count++; if (waits !== 4) begin $display("FAIL lb_wait_cycles got=%0d exp=4", waits); miscompares++; end
        vec_count++; if (WB_VALID !== 1'b1 || WB_REG_W_DATA !== 32'hFFFFFF80) begin $display("FAIL lb_data got=%b/%h exp=1/ffffff80", WB_VALID, WB_REG_W_DATA); miscompares++; end
        vec_count++; if (WB_REG_W_EN !== 1'b1 || WB_REG_W_RD !== 5'd7 || WB_PC !== 32'h200) begin $display("FAIL lb_rd got=%b/%0d/%h exp=1/7/00000200", WB_REG_W_EN, WB_REG_W_RD, WB_PC); miscompares++; end
        vec_count++; if (DBUS_REQ !== 1'b0 || MEM_WAIT !== 1'b0) begin $display("FAIL lb_release got=%b/%b exp=0/0", DBUS_REQ, MEM_WAIT); miscompares++; end
        $display("lb: addr=2003 rdata=80123456 wb=%h", WB_REG_W_DATA);
    endtask

    task automatic test_load_half_unsigned();
        drive_load(32'h204, 5'd9, 32'h3002, 4'b0011, 1'b0);
        tick();
        clear_inputs();
        vec_count++; if (DBUS_STRB !== 4'b1100) begin $display("FAIL lhu_strb got=%b exp=1100", DBUS_STRB); miscompares++; end
        DBUS_ACK = 1; DBUS_RDATA = 32'h8001ABCD;
        tick();
        DBUS_ACK = 0;
        vec_count++; if (WB_VALID !== 1'b1 || WB_REG_W_DATA !== 32'h00008001) begin $display("FAIL lhu_data got=%b/%h exp=1/00008001", WB_VALID, WB_REG_W_DATA); miscompares++; end
        $display("lhu: addr=3002 rdata=8001abcd wb=%h", WB_REG_W_DATA);
    endtask

    task automatic test_load_rd_zero();
        drive_load(32'h208, 5'd0, 32'h3000, 4'b1111, 1'b0);
        tick();
        clear_inputs();
        DBUS_ACK = 1; DBUS_RDATA = 32'hCAFEF00D;
        tick();
        DBUS_ACK = 0;
        vec_count++; if (WB_VALID !== 1'b1 || WB_REG_W_EN !== 1'b0 || WB_REG_W_DATA !== 32'hCAFEF00D) begin $display("FAIL lw_rd0 got=%b/%b/%h exp=1/0/cafef00d", WB_VALID, WB_REG_W_EN, WB_REG_W_DATA); miscompares++; end
        $display("lw: rd=0 rdata=cafef00d");
    endtask

    task automatic test_store_half();
        IN_VALID = 1; IN_PC = 32'h300; IN_MEM_W_EN = 1; IN_MEM_W_ADDR = 32'h1002;
        IN_MEM_W_STRB = 4'b0011; IN_MEM_W_DATA = 32'h1234;
        IN_CSR_W_EN = 1; IN_CSR_W_ADDR = 12'h340; IN_CSR_W_DATA = 32'h55;
        tick();
        clear_inputs();
        vec_count++; if (DBUS_ADDR !== 32'h1000 || DBUS_STRB !== 4'b1100) begin $display("FAIL sh_addr_strb got=%h/%b exp=00001000/1100", DBUS_ADDR, DBUS_STRB); miscompares++; end
        vec_count++; if (DBUS_WDATA !== 32'h12340000 || DBUS_WE !== 1'b1 || DBUS_REQ !== 1'b1) begin $display("FAIL sh_wdata got=%h/%b/%b exp=12340000/1/1", DBUS_WDATA, DBUS_WE, DBUS_REQ); miscompares++; end
        tick();
        vec_count++; if (DBUS_ADDR !== 32'h1000 || DBUS_WDATA !== 32'h12340000) begin $display("FAIL sh_hold got=%h/%h exp=00001000/12340000", DBUS_ADDR, DBUS_WDATA); miscompares++; end
        DBUS_ACK = 1;
        tick();
        DBUS_ACK = 0;
        vec_count++; if (WB_VALID !== 1'b1 || WB_EXC_EN !== 1'b0 || WB_REG_W_EN !== 1'b0) begin $display("FAIL sh_wb got=%b/%b/%b exp=1/0/0", WB_VALID, WB_EXC_EN, WB_REG_W_EN); miscompares++; end
        vec_count++; if (WB_CSR_W_EN !== 1'b1 || WB_CSR_W_ADDR !== 12'h340 || WB_PC !== 32'h300) begin $display("FAIL sh_passthru got=%b/%h/%h exp=1/340/00000300", WB_CSR_W_EN, WB_CSR_W_ADDR, WB_PC); miscompares++; end
        $display("sh: addr=1002 data=1234");
    endtask

    task automatic test_misaligned();
        drive_load(32'h400, 5'd3, 32'h1001, 4'b1111, 1'b0);
        tick();
        clear_inputs();
        vec_count++; if (DBUS_REQ !== 1'b0 || MEM_WAIT !== 1'b0) begin $display("FAIL lw_mis_nobus got=%b/%b exp=0/0", DBUS_REQ, MEM_WAIT); miscompares++; end
        vec_count++; if (WB_VALID !== 1'b1 || WB_EXC_EN !== 1'b1 || WB_EXC_CODE !== 4'd4) begin $display("FAIL lw_mis_exc got=%b/%b/%0d exp=1/1/4", WB_VALID, WB_EXC_EN, WB_EXC_CODE); miscompares++; end
        IN_VALID = 1; IN_PC = 32'h404; IN_MEM_W_EN = 1; IN_MEM_W_ADDR = 32'h5; IN_MEM_W_STRB = 4'b0011;
        tick();
        clear_inputs();
        vec_count++; if (DBUS_REQ !== 1'b0 || WB_EXC_EN !== 1'b1 || WB_EXC_CODE !== 4'd6) begin $display("FAIL sh_mis_exc got=%b/%b/%0d exp=0/1/6", DBUS_REQ, WB_EXC_EN, WB_EXC_CODE); miscompares++; end
        $display("misaligned: lw@1001 sh@0005");
    endtask

    task automatic test_exc_passthrough();
        drive_load(32'h500, 5'd4, 32'h1001, 4'b1111, 1'b0);
        IN_EXC_EN = 1; IN_EXC_CODE = 4'd2;
        tick();
        clear_inputs();
        vec_count++; if (DBUS_REQ !== 1'b0 || WB_EXC_EN !== 1'b1 || WB_EXC_CODE !== 4'd2) begin $display("FAIL exc_pass got=%b/%b/%0d exp=0/1/2", DBUS_REQ, WB_EXC_EN, WB_EXC_CODE); miscompares++; end
        $display("exc passthrough: code=2");
    endtask

    task automatic test_bus_err();
        drive_load(32'h600, 5'd6, 32'h4000, 4'b1111, 1'b0);
        tick();
        clear_inputs();
        DBUS_ACK = 1; DBUS_ERR = 1;
        tick();
        DBUS_ACK = 0; DBUS_ERR = 0;
        vec_count++; if (WB_VALID !== 1'b1 || WB_EXC_EN !== 1'b1 || WB_EXC_CODE !== 4'd5 || WB_REG_W_EN !== 1'b0) begin $display("FAIL lw_err got=%b/%b/%0d/%b exp=1/1/5/0", WB_VALID, WB_EXC_EN, WB_EXC_CODE, WB_REG_W_EN); miscompares++; end
        $display("bus err: lw@4000");
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive_load(32'h700, 5'd8, 32'h4000, 4'b1111, 1'b0);
        tick();
        clear_inputs();
        while (DBUS_REQ && req_cycles < 400) begin
            req_cycles++;
            tick();
        end
        vec_count++; if (req_cycles !== 256) begin $display("FAIL timeout_cycles got=%0d exp=256", req_cycles); miscompares++; end
        vec_count++; if (MEM_WAIT !== 1'b1 || WB_VALID !== 1'b0) begin $display("FAIL timeout_drain got=%b/%b exp=1/0", MEM_WAIT, WB_VALID); miscompares++; end
        tick();
        vec_count++; if (WB_VALID !== 1'b1 || WB_EXC_CODE !== 4'd5 || WB_REG_W_EN !== 1'b0 || MEM_WAIT !== 1'b0) begin $display("FAIL timeout_wb got=%b/%0d/%b/%b exp=1/5/0/0", WB_VALID, WB_EXC_CODE, WB_REG_W_EN, MEM_WAIT); miscompares++; end
        $display("timeout: req cycles=%0d", req_cycles);
    endtask

    task automatic test_flush_bus();
        drive_load(32'h800, 5'd2, 32'h4000, 4'b1111, 1'b0);
        tick();
        clear_inputs();
        FLUSH = 1;
        tick();
        FLUSH = 0;
        vec_count++; if (DBUS_REQ !== 1'b1 || MEM_WAIT !== 1'b1) begin $display("FAIL flush_hold got=%b/%b exp=1/1", DBUS_REQ, MEM_WAIT); miscompares++; end
        tick();
        vec_count++; if (DBUS_REQ !== 1'b1 || WB_VALID !== 1'b0) begin $display("FAIL flush_drain got=%b/%b exp=1/0", DBUS_REQ, WB_VALID); miscompares++; end
        DBUS_ACK = 1; DBUS_RDATA = 32'h11112222;
        tick();
        DBUS_ACK = 0;
        vec_count++; if (DBUS_REQ !== 1'b0 || WB_VALID !== 1'b0 || MEM_WAIT !== 1'b0) begin $display("FAIL flush_done got=%b/%b/%b exp=0/0/0", DBUS_REQ, WB_VALID, MEM_WAIT); miscompares++; end
        $display("flush in bus: drained");
    endtask

    task automatic test_flush_idle();
        IN_VALID = 1; IN_PC = 32'h900; IN_REG_W_EN = 1; IN_REG_W_RD = 1; IN_REG_W_DATA = 32'h77;
        FLUSH = 1;
        tick();
        clear_inputs();
        vec_count++; if (WB_VALID !== 1'b0 || WB_REG_W_DATA !== 32'd0) begin $display("FAIL flush_idle got=%b/%h exp=0/0", WB_VALID, WB_REG_W_DATA); miscompares++; end
        $display("flush in idle: dropped");
    endtask

    task automatic test_back_to_back();
        IN_VALID = 1; IN_PC = 32'hA00; IN_REG_W_EN = 1; IN_REG_W_RD = 10; IN_REG_W_DATA = 32'hAAAA;
        IN_JMP_DO = 1; IN_JMP_PC = 32'hB00;
        tick();
        vec_count++; if (WB_REG_W_RD !== 5'd10 || WB_JMP_DO !== 1'b1 || WB_JMP_PC !== 32'hB00) begin $display("FAIL b2b_first got=%0d/%b/%h exp=10/1/00000b00", WB_REG_W_RD, WB_JMP_DO, WB_JMP_PC); miscompares++; end
        IN_PC = 32'hA04; IN_REG_W_RD = 11; IN_REG_W_DATA = 32'hBBBB; IN_JMP_DO = 0; IN_JMP_PC = 0;
        tick();
        clear_inputs();
        vec_count++; if (WB_VALID !== 1'b1 || WB_REG_W_RD !== 5'd11 || WB_REG_W_DATA !== 32'hBBBB || WB_JMP_DO !== 1'b0) begin $display("FAIL b2b_second got=%b/%0d/%h/%b exp=1/11/0000bbbb/0", WB_VALID, WB_REG_W_RD, WB_REG_W_DATA, WB_JMP_DO); miscompares++; end
        $display("back-to-back: two alu ops");
    endtask

    task automatic test_reset_mid_op();
        drive_load(32'hC00, 5'd12, 32'h4000, 4'b1111, 1'b0);
        tick();
        clear_inputs();
        RST = 1;
        tick();
        RST = 0;
        vec_count++; if (DBUS_REQ !== 1'b0 || MEM_WAIT !== 1'b0 || WB_VALID !== 1'b0) begin $display("FAIL rst_mid got=%b/%b/%b exp=0/0/0", DBUS_REQ, MEM_WAIT, WB_VALID); miscompares++; end
        $display("reset mid-op: cleared");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte_signed();
        test_load_half_unsigned();
        test_load_rd_zero();
        test_store_half();
        test_misaligned();
        test_exc_passthrough();
        test_bus_err();
        test_timeout();
        test_flush_bus();
        test_flush_idle();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
